iz_param_loader_multi: RTL and testbench
========================================

Name: iz_param_loader_multi

Overview:
- Serial (1-bit) configuration loader for an array of N_NEURONS Izhikevich neurons.
- Receives addressed, checksummed frames and scales the raw 8-bit fields to fixed-point a/b/c/d.
- Commits all four parameters of the target channel atomically, or of every channel on broadcast.
- Sits between the chip-level serial config pin and the neuron array. Corrupt or aborted frames never disturb live parameters.

Parameters:
- N_NEURONS, 4, number of neuron channels (1..2^ADDR_W-1).
- ADDR_W, 4, width of the frame address field (1..8). All-ones value means broadcast.
- PARAM_W, 16, width of each scaled output parameter, two's complement. Must be at least SCALE_SHIFT+8.
- SCALE_SHIFT, 6, fixed-point scale as a power of two (6 gives 64).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  clock-enable for the FSM and sampling. When low, all state holds.
- serial_data_in  in  1  frame bit, MSB first.
- load_enable  in  1  frame envelope. Its rising edge starts a frame; it must stay high for the whole frame.
- param_a_flat  out  N_NEURONS*PARAM_W  channel i occupies bits [i*PARAM_W +: PARAM_W]. Same layout for b, c and d.
- param_b_flat  out  N_NEURONS*PARAM_W
- param_c_flat  out  N_NEURONS*PARAM_W
- param_d_flat  out  N_NEURONS*PARAM_W
- busy  out  1  high while a frame is in progress.
- load_done  out  1  one-cycle pulse on a successful commit.
- load_error  out  1  one-cycle pulse on a rejected frame.
- err_code  out  2  0 none, 1 checksum, 2 bad address, 3 aborted. Held until the next frame start.
- load_state  out  3  FSM state, for debug.

Behaviour:
- Reset (async, active-high):
  - Every channel loads defaults: a=1, b=13, c=-(65<<SCALE_SHIFT), d=2<<SCALE_SHIFT.
  - busy=0, load_done=0, load_error=0, err_code=0, FSM=IDLE.
  - The edge detector and shift counters clear.
  - A reset mid-frame discards the partial frame with no commit.
- All logic below advances only on clock edges where enable=1.
- Edge detection:
  - load_enable_prev is a register.
  - A start is load_enable=1 while load_enable_prev=0.
  - serial_data_in is ignored on the start cycle. Bits are sampled on following cycles.
- Frame format: ADDR (ADDR_W bits), RAW_A, RAW_B, RAW_C, RAW_D (8 bits each), CHK (8 bits).
- Checksum: CHK = (zero-extended ADDR + RAW_A + RAW_B + RAW_C + RAW_D) mod 256.
- FSM states: IDLE, ADDR, FIELD, CHK, COMMIT, WAIT_LOW.
  - IDLE -> ADDR on a start. On that same edge: busy=1, err_code=0.
  - ADDR -> FIELD after ADDR_W bits.
  - FIELD uses a field counter 0..3 and a bit counter 0..7. Each completed byte is latched into a staging register. FIELD -> CHK after field 3.
  - CHK -> COMMIT after 8 bits.
  - COMMIT performs the commit or rejection on its single edge, then moves to WAIT_LOW.
  - WAIT_LOW -> IDLE when load_enable=0. A start seen in WAIT_LOW goes directly to ADDR.
- Abort: load_enable=0 in ADDR, FIELD or CHK. Go to IDLE, set err_code=3, pulse load_error, busy=0, no commit.
- Commit rules (evaluated in COMMIT):
  - Checksum mismatch: err_code=1.
  - Otherwise, ADDR >= N_NEURONS and ADDR not all-ones: err_code=2.
  - Otherwise: write the scaled values into the addressed channel, or into all channels when ADDR is all-ones.
  - Success pulses load_done. Any error pulses load_error and leaves every channel unchanged.
  - busy falls on the COMMIT edge.
- Latency: if edge E samples the last CHK bit, edge E+1 updates the outputs and raises the load_done/load_error pulse together.
- Scaling (raw r, 8 bits unsigned; results sign-extended to PARAM_W):
  - a = r[7:4] + 1
  - b = (r - 128) >>> 2, signed arithmetic
  - c = -((r[7:2] + 40) << SCALE_SHIFT)
  - d = r[7:4] << SCALE_SHIFT
- Unaddressed channels never change. Outputs are registered; there is no glitch or partial update between parameters.

Decomposition:
- Package iz_loader_pkg:
  - State encoding localparams.
  - Error code constants.
  - Default raw and scaled values.
  - Field indices.
- Sub-module iz_param_scaler: combinational; raw A/B/C/D plus SCALE_SHIFT in, four PARAM_W values out. Shared with the verification reference model.

Test Plan:
- Reset, then read all channels -> a=0x0001, b=0x000D, c=0xEFC0, d=0x0080; busy=0.
- Frame to ADDR=2 with A=0x30, B=0xA0, C=0x64, D=0x50, CHK=0x86 -> channel 2 gets a=4, b=8, c=0xEFC0, d=320, load_done pulses at E+1; channels 0, 1 and 3 unchanged.
- Same frame with CHK=0x85 -> load_error pulses, err_code=1, all channels unchanged.
- Broadcast ADDR=0xF, B=0x20, A=C=D=0x00, CHK=0x2F -> every channel b=0xFFE8, a=1, c=-(40<<6)=0xF600, d=0.
- ADDR=5 with valid CHK and N_NEURONS=4 -> err_code=2, no change. Separately, drop load_enable after 12 bits -> err_code=3, load_error pulses, busy=0.
- Hold enable=0 for 5 cycles mid-frame, then resume -> identical commit to the uninterrupted case. Assert reset mid-FIELD -> defaults immediately, no commit.

Source files
------------

// File: rtl/iz_loader_pkg.sv
// Shared definitions for the Izhikevich parameter loader: FSM encoding,
// error codes, field indices, default neuron parameters and the frame checksum.
package iz_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_FIELD    = 3'd2,
        ST_CHK      = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_WAIT_LOW = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CHKSUM = 2'd1;
    localparam logic [1:0] ERR_ADDR   = 2'd2;
    localparam logic [1:0] ERR_ABORT  = 2'd3;

    localparam int FIELD_A  = 0;
    localparam int FIELD_B  = 1;
    localparam int FIELD_C  = 2;
    localparam int FIELD_D  = 3;
    localparam int N_FIELDS = 4;

    // Defaults before fixed-point scaling: c = -(65 << shift), d = 2 << shift.
    localparam int DEF_A      = 1;
    localparam int DEF_B      = 13;
    localparam int DEF_C_BASE = 65;
    localparam int DEF_D_BASE = 2;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0] addr,
        input logic [7:0] ra,
        input logic [7:0] rb,
        input logic [7:0] rc,
        input logic [7:0] rd
    );
        return addr + ra + rb + rc + rd;
    endfunction

endpackage

// File: rtl/iz_param_scaler.sv
// Combinational mapping from the four raw 8-bit frame fields to the
// fixed-point Izhikevich a/b/c/d values.
module iz_param_scaler #(
    parameter int PARAM_W     = 16,
    parameter int SCALE_SHIFT = 6
) (
    input  logic [7:0]         raw_a_i,
    input  logic [7:0]         raw_b_i,
    input  logic [7:0]         raw_c_i,
    input  logic [7:0]         raw_d_i,
    output logic [PARAM_W-1:0] a_o,
    output logic [PARAM_W-1:0] b_o,
    output logic [PARAM_W-1:0] c_o,
    output logic [PARAM_W-1:0] d_o
);

    logic signed [8:0]  b_off;
    logic signed [8:0]  b_sh;
    logic        [6:0]  c_base;
    logic [PARAM_W-1:0] c_mag;

    assign a_o = {{(PARAM_W-5){1'b0}}, ({1'b0, raw_a_i[7:4]} + 5'd1)};

    // Re-centre b around zero before the arithmetic shift so it keeps its sign.
    assign b_off = $signed({1'b0, raw_b_i}) - 9'sd128;
    assign b_sh  = b_off >>> 2;
    assign b_o   = {{(PARAM_W-9){b_sh[8]}}, b_sh};

    assign c_base = {1'b0, raw_c_i[7:2]} + 7'd40;
    assign c_mag  = {{(PARAM_W-7){1'b0}}, c_base} << SCALE_SHIFT;
    assign c_o    = -c_mag;

    assign d_o = {{(PARAM_W-4){1'b0}}, raw_d_i[7:4]} << SCALE_SHIFT;

endmodule

// File: rtl/iz_param_loader_multi.sv
// Serial configuration loader: receives addressed, checksummed frames and
// atomically commits scaled a/b/c/d to one neuron channel or all of them.
module iz_param_loader_multi
    import iz_loader_pkg::*;
#(
    parameter int N_NEURONS   = 4,
    parameter int ADDR_W      = 4,
    parameter int PARAM_W     = 16,
    parameter int SCALE_SHIFT = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           serial_data_in,
    input  logic                           load_enable,
    output logic [N_NEURONS*PARAM_W-1:0]   param_a_flat,
    output logic [N_NEURONS*PARAM_W-1:0]   param_b_flat,
    output logic [N_NEURONS*PARAM_W-1:0]   param_c_flat,
    output logic [N_NEURONS*PARAM_W-1:0]   param_d_flat,
    output logic                           busy,
    output logic                           load_done,
    output logic                           load_error,
    output logic [1:0]                     err_code,
    output logic [2:0]                     load_state
);

    localparam logic [PARAM_W-1:0] DEF_A_S = PARAM_W'(DEF_A);
    localparam logic [PARAM_W-1:0] DEF_B_S = PARAM_W'(DEF_B);
    localparam logic [PARAM_W-1:0] DEF_C_S = PARAM_W'(-(DEF_C_BASE << SCALE_SHIFT));
    localparam logic [PARAM_W-1:0] DEF_D_S = PARAM_W'(DEF_D_BASE << SCALE_SHIFT);
    localparam logic [ADDR_W-1:0]  BCAST   = '1;
    localparam logic [2:0]         ADDR_LAST = 3'(ADDR_W - 1);

    state_t              state_q, state_d;
    logic                le_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          field_cnt_q, field_cnt_d;
    logic [7:0]          raw_q [N_FIELDS];
    logic [7:0]          raw_d [N_FIELDS];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [PARAM_W-1:0]  pa_q [N_NEURONS];
    logic [PARAM_W-1:0]  pb_q [N_NEURONS];
    logic [PARAM_W-1:0]  pc_q [N_NEURONS];
    logic [PARAM_W-1:0]  pd_q [N_NEURONS];
    logic [PARAM_W-1:0]  pa_d [N_NEURONS];
    logic [PARAM_W-1:0]  pb_d [N_NEURONS];
    logic [PARAM_W-1:0]  pc_d [N_NEURONS];
    logic [PARAM_W-1:0]  pd_d [N_NEURONS];

    logic [PARAM_W-1:0]  sc_a, sc_b, sc_c, sc_d;
    logic                start;
    logic [7:0]          byte_in;
    logic [7:0]          chk_calc;
    logic                bcast;
    logic                in_range;

    iz_param_scaler #(
        .PARAM_W     (PARAM_W),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_scaler (
        .raw_a_i (raw_q[FIELD_A]),
        .raw_b_i (raw_q[FIELD_B]),
        .raw_c_i (raw_q[FIELD_C]),
        .raw_d_i (raw_q[FIELD_D]),
        .a_o     (sc_a),
        .b_o     (sc_b),
        .c_o     (sc_c),
        .d_o     (sc_d)
    );

    assign start    = load_enable & ~le_prev_q;
    assign byte_in  = {shift_q[6:0], serial_data_in};
    assign chk_calc = frame_checksum(8'(addr_q), raw_q[FIELD_A], raw_q[FIELD_B],
                                     raw_q[FIELD_C], raw_q[FIELD_D]);
    assign bcast    = (addr_q == BCAST);
    assign in_range = (32'(addr_q) < 32'(N_NEURONS));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        field_cnt_d = field_cnt_q;
        raw_d       = raw_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        pa_d        = pa_q;
        pb_d        = pb_q;
        pc_d        = pc_q;
        pd_d        = pd_q;

        case (state_q)
            ST_IDLE, ST_WAIT_LOW: begin
                if (start) begin
                    state_d     = ST_ADDR;
                    busy_d      = 1'b1;
                    code_d      = ERR_NONE;
                    bit_cnt_d   = 3'd0;
                    field_cnt_d = 2'd0;
                end else if (state_q == ST_WAIT_LOW && !load_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR, ST_FIELD, ST_CHK: begin
                if (!load_enable) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                end else begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (state_q == ST_ADDR) begin
                        addr_d = ADDR_W'({addr_q, serial_data_in});
                        if (bit_cnt_q == ADDR_LAST) begin
                            state_d   = ST_FIELD;
                            bit_cnt_d = 3'd0;
                        end
                    end else if (state_q == ST_FIELD) begin
                        if (bit_cnt_q == 3'd7) begin
                            raw_d[field_cnt_q] = byte_in;
                            field_cnt_d        = field_cnt_q + 2'd1;
                            if (field_cnt_q == 2'd3) state_d = ST_CHK;
                        end
                    end else if (bit_cnt_q == 3'd7) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                // The received checksum byte is still sitting in shift_q here.
                state_d = ST_WAIT_LOW;
                busy_d  = 1'b0;
                if (chk_calc != shift_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_CHKSUM;
                end else if (!bcast && !in_range) begin
                    err_d  = 1'b1;
                    code_d = ERR_ADDR;
                end else begin
                    done_d = 1'b1;
                    for (int i = 0; i < N_NEURONS; i++) begin
                        if (bcast || 32'(addr_q) == 32'(i)) begin
                            pa_d[i] = sc_a;
                            pb_d[i] = sc_b;
                            pc_d[i] = sc_c;
                            pd_d[i] = sc_d;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            le_prev_q   <= 1'b0;
            addr_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            field_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
            for (int f = 0; f < N_FIELDS; f++) raw_q[f] <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                pa_q[i] <= DEF_A_S;
                pb_q[i] <= DEF_B_S;
                pc_q[i] <= DEF_C_S;
                pd_q[i] <= DEF_D_S;
            end
        end else if (enable) begin
            state_q     <= state_d;
            le_prev_q   <= load_enable;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            field_cnt_q <= field_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            raw_q       <= raw_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            pc_q        <= pc_d;
            pd_q        <= pd_d;
        end
    end

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_flat
        assign param_a_flat[gi*PARAM_W +: PARAM_W] = pa_q[gi];
        assign param_b_flat[gi*PARAM_W +: PARAM_W] = pb_q[gi];
        assign param_c_flat[gi*PARAM_W +: PARAM_W] = pc_q[gi];
        assign param_d_flat[gi*PARAM_W +: PARAM_W] = pd_q[gi];
    end

    assign busy       = busy_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign err_code   = code_q;
    assign load_state = state_q;

endmodule

// File: tb/tb_iz_param_loader_multi.sv
// Directed-frame bench for iz_param_loader_multi with an expected-outcome
// scoreboard and an independent arithmetic model of the parameter scaling.
module tb_iz_param_loader_multi;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int PW = 16;
    localparam int SS = 6;
    localparam int FB = AW + 40;

    logic clk = 1'b0;
    logic reset, enable, serial_data_in, load_enable;
    logic [N*PW-1:0] pa, pb, pc, pd;
    logic busy, load_done, load_error;
    logic [1:0] err_code;
    logic [2:0] load_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic [2:0]    state;
        logic [PW-1:0] a [N];
        logic [PW-1:0] b [N];
        logic [PW-1:0] c [N];
        logic [PW-1:0] d [N];
    } exp_t;

    exp_t sb [$];
    logic [PW-1:0] m_a [N];
    logic [PW-1:0] m_b [N];
    logic [PW-1:0] m_c [N];
    logic [PW-1:0] m_d [N];

    iz_param_loader_multi #(
        .N_NEURONS   (N),
        .ADDR_W      (AW),
        .PARAM_W     (PW),
        .SCALE_SHIFT (SS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .serial_data_in (serial_data_in),
        .load_enable    (load_enable),
        .param_a_flat   (pa),
        .param_b_flat   (pb),
        .param_c_flat   (pc),
        .param_d_flat   (pd),
        .busy           (busy),
        .load_done      (load_done),
        .load_error     (load_error),
        .err_code       (err_code),
        .load_state     (load_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [PW-1:0] ref_a(int r); return PW'(r / 16 + 1); endfunction
    function automatic logic [PW-1:0] ref_b(int r); return PW'(r / 4 - 32); endfunction
    function automatic logic [PW-1:0] ref_c(int r); return PW'(-((r / 4 + 40) * (1 << SS))); endfunction
    function automatic logic [PW-1:0] ref_d(int r); return PW'((r / 16) * (1 << SS)); endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_a[i] = 16'h0001;
            m_b[i] = 16'h000D;
            m_c[i] = 16'hEFC0;
            m_d[i] = 16'h0080;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_params(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.a%0d", tag, i), 32'(pa[i*PW +: PW]), 32'(m_a[i]));
            check($sformatf("%s.b%0d", tag, i), 32'(pb[i*PW +: PW]), 32'(m_b[i]));
            check($sformatf("%s.c%0d", tag, i), 32'(pc[i*PW +: PW]), 32'(m_c[i]));
            check($sformatf("%s.d%0d", tag, i), 32'(pd[i*PW +: PW]), 32'(m_d[i]));
        end
    endtask

    task automatic check_outcome(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".done"},  32'(load_done),  32'(e.done));
        check({tag, ".error"}, 32'(load_error), 32'(e.err));
        check({tag, ".code"},  32'(err_code),   32'(e.code));
        check({tag, ".busy"},  32'(busy),       32'd0);
        check({tag, ".state"}, 32'(load_state), 32'(e.state));
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.a%0d", tag, i), 32'(pa[i*PW +: PW]), 32'(e.a[i]));
            check($sformatf("%s.b%0d", tag, i), 32'(pb[i*PW +: PW]), 32'(e.b[i]));
            check($sformatf("%s.c%0d", tag, i), 32'(pc[i*PW +: PW]), 32'(e.c[i]));
            check($sformatf("%s.d%0d", tag, i), 32'(pd[i*PW +: PW]), 32'(e.d[i]));
        end
    endtask

    // abort_at < FB drops load_enable after that many bits; pause_at stalls enable for 5 cycles.
    task automatic run_frame(input string tag, input logic [AW-1:0] addr,
                             input logic [7:0] ra, input logic [7:0] rb,
                             input logic [7:0] rc, input logic [7:0] rd,
                             input logic [7:0] chk, input int abort_at, input int pause_at);
        exp_t e;
        logic [FB-1:0] v;
        int sum, nbits;
        v     = {addr, ra, rb, rc, rd, chk};
        sum   = (int'(addr) + int'(ra) + int'(rb) + int'(rc) + int'(rd)) % 256;
        nbits = (abort_at < FB) ? abort_at : FB;
        e.done = 1'b0; e.err = 1'b1; e.state = 3'd5;
        if (abort_at < FB) begin
            e.code = 2'd3; e.state = 3'd0;
        end else if (sum != int'(chk)) begin
            e.code = 2'd1;
        end else if (int'(addr) >= N && addr != 4'hF) begin
            e.code = 2'd2;
        end else begin
            e.code = 2'd0; e.done = 1'b1; e.err = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (addr == 4'hF || int'(addr) == i) begin
                    m_a[i] = ref_a(int'(ra));
                    m_b[i] = ref_b(int'(rb));
                    m_c[i] = ref_c(int'(rc));
                    m_d[i] = ref_d(int'(rd));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            e.a[i] = m_a[i]; e.b[i] = m_b[i]; e.c[i] = m_c[i]; e.d[i] = m_d[i];
        end
        sb.push_back(e);

        @(negedge clk);
        load_enable    = 1'b1;
        serial_data_in = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            serial_data_in = v[FB-1-i];
            if (i == 20) check({tag, ".busy_mid"}, 32'(busy), 32'd1);
            if (i == pause_at) begin
                enable = 1'b0;
                repeat (5) @(negedge clk);
                enable = 1'b1;
            end
        end
        if (abort_at < FB) begin
            @(negedge clk);
            load_enable = 1'b0;
            @(negedge clk);
        end else begin
            @(negedge clk);
            @(negedge clk);
        end
        check_outcome(tag);
        load_enable = 1'b0;
        @(negedge clk);
        check({tag, ".pulse_end_done"}, 32'(load_done),  32'd0);
        check({tag, ".pulse_end_err"},  32'(load_error), 32'd0);
        check({tag, ".code_held"},      32'(err_code),   32'(e.code));
        check({tag, ".idle"},           32'(load_state), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb, rc, rd;
        logic [AW-1:0] ad;
        reset          = 1'b0;
        enable         = 1'b1;
        load_enable    = 1'b0;
        serial_data_in = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.busy",  32'(busy),       32'd0);
        check("rst.done",  32'(load_done),  32'd0);
        check("rst.error", 32'(load_error), 32'd0);
        check("rst.code",  32'(err_code),   32'd0);
        check("rst.state", 32'(load_state), 32'd0);
        check_params("rst");
        reset = 1'b0;
        @(negedge clk);

        run_frame("ch2_ok",    4'd2, 8'h30, 8'hA0, 8'h64, 8'h50, 8'h86, FB, -1);
        check("ch2_ok.a2_lit", 32'(pa[2*PW +: PW]), 32'h0004);
        check("ch2_ok.d2_lit", 32'(pd[2*PW +: PW]), 32'd320);
        run_frame("ch2_badchk", 4'd2, 8'h30, 8'hA0, 8'h64, 8'h50, 8'h85, FB, -1);
        run_frame("bcast",     4'hF, 8'h00, 8'h20, 8'h00, 8'h00, 8'h2F, FB, -1);
        check("bcast.b0_lit", 32'(pb[0 +: PW]), 32'h0000FFE8);
        check("bcast.c3_lit", 32'(pc[3*PW +: PW]), 32'h0000F600);
        run_frame("badaddr",   4'd5, 8'h11, 8'h11, 8'h11, 8'h11, 8'h49, FB, -1);
        run_frame("abort12",   4'd1, 8'h30, 8'hA0, 8'h64, 8'h50, 8'h85, 12, -1);
        run_frame("paused",    4'd1, 8'h30, 8'hA0, 8'h64, 8'h50, 8'h85, FB, 10);
        run_frame("ch0_ff",    4'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, FB, -1);
        check("ch0_ff.c0_lit", 32'(pc[0 +: PW]), 32'h0000E640);

        for (int k = 0; k < 3; k++) begin
            ad = AW'(k + 1);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            run_frame($sformatf("rnd%0d", k), ad, ra, rb, rc, rd,
                      8'(int'(ad) + int'(ra) + int'(rb) + int'(rc) + int'(rd)), FB, -1);
        end

        // Reset in the middle of the FIELD phase: defaults appear at once, no commit follows.
        @(negedge clk);
        load_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            serial_data_in = 1'($urandom_range(0, 1));
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_params("midrst");
        check("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        load_enable = 1'b0;
        reset       = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.done",  32'(load_done),  32'd0);
        check("midrst.state", 32'(load_state), 32'd0);
        check_params("midrst_after");

        run_frame("post_rst",  4'd3, 8'h30, 8'hA0, 8'h64, 8'h50, 8'h87, FB, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
